// File: rtl/uart_cmd_ctrl_if.sv
// Byte-receiver handshake and register-write bus of the UART command-frame controller.
interface uart_cmd_ctrl_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        wr_stb;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  modport master (
    input  rx_done, rx_data,
    output rx_en, wr_stb, wr_addr, wr_data, frame_err, err_cnt, busy
  );

  modport slave (
    output rx_done, rx_data,
    input  rx_en, wr_stb, wr_addr, wr_data, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte UART command frames (header, addr, dhi, dlo, checksum) into register writes.
// Define UART_CMD_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYC idle clocks.
module uart_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         NREG        = 4,
  parameter int         TIMEOUT_CYC = 49152
) (
  input logic            clk,
  input logic            rst,
  uart_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM} state_e;

  localparam logic [7:0] NREG_B = 8'(NREG);

  state_e      state_q;
  logic [7:0]  addr_q, dhi_q, dlo_q;
  logic        rx_en_q, wr_stb_q, frame_err_q;
  logic [1:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic [7:0]  err_cnt_q;

  logic [7:0]  sum_d;
  logic        frame_ok_d;
  logic        timeout_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    sum_d      = HEADER + addr_q + dhi_q + dlo_q;
    frame_ok_d = (bus.rx_data == sum_d) && (addr_q < NREG_B);
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] to_cnt_q;

  // A byte arriving on the expiry cycle wins: rx_done masks the timeout.
  assign timeout_d = (state_q != S_IDLE) && !bus.rx_done &&
                     (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (bus.rx_done || state_q == S_IDLE || timeout_d) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_d = 1'b0;
`endif

  // NOTE: every register, including the frame byte latches, is in the async
  // reset and assigned non-blocking so all of them update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      rx_en_q     <= 1'b0;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      rx_en_q     <= !bus.rx_done;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.rx_done) begin
        unique case (state_q)
          S_IDLE: if (bus.rx_data == HEADER) state_q <= S_ADDR;
          S_ADDR: begin
            addr_q  <= bus.rx_data;
            state_q <= S_DHI;
          end
          S_DHI: begin
            dhi_q   <= bus.rx_data;
            state_q <= S_DLO;
          end
          S_DLO: begin
            dlo_q   <= bus.rx_data;
            state_q <= S_CSUM;
          end
          S_CSUM: begin
            if (frame_ok_d) begin
              wr_addr_q <= addr_q[1:0];
              wr_data_q <= {dhi_q, dlo_q};
              wr_stb_q  <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (timeout_d) begin
        frame_err_q <= 1'b1;
        err_cnt_q   <= sat_inc(err_cnt_q);
        state_q     <= S_IDLE;
      end
    end
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame table, corner sequences, random frames vs a queue model.
module tb_uart_cmd_ctrl;

  localparam int         T      = 64;
  localparam logic [7:0] HDR    = 8'h55;
  localparam int         NREG_M = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_ctrl_if ifc ();

  uart_cmd_ctrl #(.HEADER(HDR), .NREG(NREG_M), .TIMEOUT_CYC(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic stb, input logic err,
                           input logic [1:0] addr, input logic [15:0] data,
                           input logic [7:0] cnt, input logic busy, input logic rx_en);
    check({tag, ".wr_stb"},    ifc.wr_stb,    stb);
    check({tag, ".frame_err"}, ifc.frame_err, err);
    check({tag, ".wr_addr"},   ifc.wr_addr,   addr);
    check({tag, ".wr_data"},   ifc.wr_data,   data);
    check({tag, ".err_cnt"},   ifc.err_cnt,   cnt);
    check({tag, ".busy"},      ifc.busy,      busy);
    check({tag, ".rx_en"},     ifc.rx_en,     rx_en);
  endtask

  // Caller is always positioned 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    ifc.rx_done = 1'b1;
    ifc.rx_data = b;
    @(posedge clk);
    #1;
    ifc.rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle.wr_stb",    ifc.wr_stb,    1'b0);
      check("idle.frame_err", ifc.frame_err, 1'b0);
      check("idle.rx_en",     ifc.rx_en,     1'b1);
    end
  endtask

  // Reference model: bytes collect into a frame once a header is seen.
  logic [7:0]  fq [$];
  logic [1:0]  m_addr;
  logic [15:0] m_data;
  int          m_cnt;

  task automatic model_byte(input logic [7:0] b, output logic stb, output logic err);
    int sum;
    stb = 1'b0;
    err = 1'b0;
    if (fq.size() == 0) begin
      if (b == HDR) fq.push_back(b);
    end else begin
      fq.push_back(b);
      if (fq.size() == 5) begin
        sum = (int'(fq[0]) + int'(fq[1]) + int'(fq[2]) + int'(fq[3])) % 256;
        if (int'(fq[4]) == sum && int'(fq[1]) < NREG_M) begin
          stb    = 1'b1;
          m_addr = fq[1][1:0];
          m_data = {fq[2], fq[3]};
        end else begin
          err   = 1'b1;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        fq.delete();
      end
    end
  endtask

  typedef struct {
    logic [55:0] bytes;  // first byte in the top octet
    int          n;
    logic        stb;
    logic        err;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0]  b;
    logic        e_stb, e_err;
    logic [7:0]  exp_cnt;
    logic [7:0]  r_addr, r_dhi, r_dlo, r_sum;
    int          kind;

    ifc.rx_done = 1'b0;
    ifc.rx_data = 8'h00;

    vecs[0] = '{56'h55_01_12_34_9C_00_00, 5, 1'b1, 1'b0, 2'd1, 16'h1234, 8'd0};
    vecs[1] = '{56'h55_01_12_34_9D_00_00, 5, 1'b0, 1'b1, 2'd1, 16'h1234, 8'd1};
    // Leading junk is dropped; the checksum of 55 03 AB CD is D0.
    vecs[2] = '{56'h00_FF_55_03_AB_CD_D0, 7, 1'b1, 1'b0, 2'd3, 16'hABCD, 8'd1};
    vecs[3] = '{56'h55_07_00_00_5C_00_00, 5, 1'b0, 1'b1, 2'd3, 16'hABCD, 8'd2};
    vecs[4] = '{56'h55_02_00_01_58_00_00, 5, 1'b1, 1'b0, 2'd2, 16'h0001, 8'd2};
    vecs[5] = '{56'h55_55_00_00_FF_00_00, 5, 1'b0, 1'b1, 2'd2, 16'h0001, 8'd3};

    #2;
    check_all("reset", 1'b0, 1'b0, 2'd0, 16'h0, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        b = vecs[v].bytes[55 - 8*i -: 8];
        send_byte(b);
        if (i < vecs[v].n - 1) begin
          check($sformatf("vec%0d.b%0d.wr_stb", v, i),    ifc.wr_stb,    1'b0);
          check($sformatf("vec%0d.b%0d.frame_err", v, i), ifc.frame_err, 1'b0);
        end
      end
      check_all($sformatf("vec%0d", v), vecs[v].stb, vecs[v].err, vecs[v].addr,
                vecs[v].data, vecs[v].cnt, 1'b0, 1'b0);
      idle(2);
    end
    exp_cnt = 8'd3;

    // Partial frame followed by a long silence.
    send_byte(8'h55);
    send_byte(8'h01);
`ifdef UART_CMD_TIMEOUT_EN
    idle(T - 1);
    check("to.pre_busy", ifc.busy, 1'b1);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check_all("to.expire", 1'b0, 1'b1, 2'd2, 16'h0001, exp_cnt, 1'b0, 1'b1);
    idle(1);
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h58);
    check_all("to.next", 1'b1, 1'b0, 2'd2, 16'h0001, exp_cnt, 1'b0, 1'b0);
    idle(1);
    // A byte on the expiry cycle is taken and the frame survives.
    send_byte(8'h55);
    send_byte(8'h01);
    idle(T - 1);
    send_byte(8'h12);
    check_all("to.race", 1'b0, 1'b0, 2'd2, 16'h0001, exp_cnt, 1'b1, 1'b0);
    send_byte(8'h34);
    send_byte(8'h9C);
    check_all("to.race_wr", 1'b1, 1'b0, 2'd1, 16'h1234, exp_cnt, 1'b0, 1'b0);
`else
    idle(3 * T);
    check("noto.busy", ifc.busy, 1'b1);
    check("noto.cnt", ifc.err_cnt, exp_cnt);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h9C);
    check_all("noto.wr", 1'b1, 1'b0, 2'd1, 16'h1234, exp_cnt, 1'b0, 1'b0);
`endif
    idle(2);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h12);
    #2;
    rst = 1'b1;
    #1;
    check_all("midrst", 1'b0, 1'b0, 2'd0, 16'h0, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h55);
    check_all("midrst.wr", 1'b1, 1'b0, 2'd0, 16'h0, 8'd0, 1'b0, 1'b0);
    idle(1);

    // Saturation of the error counter over 256 bad frames sent back to back.
    for (int k = 0; k < 256; k++) begin
      send_byte(8'h55); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h9D);
      check("sat.frame_err", ifc.frame_err, 1'b1);
      check($sformatf("sat.cnt%0d", k), ifc.err_cnt, (k < 255) ? k + 1 : 255);
    end
    check("sat.no_wr", ifc.wr_stb, 1'b0);
    idle(2);

    // Randomized frames, junk and corruptions against the queue model.
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fq.delete();
    m_addr = 2'd0;
    m_data = 16'h0;
    m_cnt  = 0;
    idle(1);
    for (int f = 0; f < 300; f++) begin
      kind   = $urandom_range(0, 3);
      r_addr = 8'($urandom_range(0, 7));
      r_dhi  = 8'($urandom);
      r_dlo  = 8'($urandom);
      r_sum  = HDR + r_addr + r_dhi + r_dlo;
      if (kind == 2) r_sum = r_sum ^ 8'($urandom_range(1, 255));
      for (int i = 0; i < ((kind == 0) ? 1 : 5); i++) begin
        case (i)
          0:       b = (kind == 0) ? 8'($urandom) : HDR;
          1:       b = r_addr;
          2:       b = r_dhi;
          3:       b = r_dlo;
          default: b = r_sum;
        endcase
        send_byte(b);
        model_byte(b, e_stb, e_err);
        check_all($sformatf("rnd%0d.b%0d", f, i), e_stb, e_err, m_addr, m_data,
                  8'(m_cnt), (fq.size() != 0), 1'b0);
        idle($urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
